// File: rtl/stream_pkg.sv
// Shared types and helpers for stream schedulers.
// Holds the arbiter state type and the rotate-priority search.
package stream_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH_BYTES = 4;

    // First requester above ptr, wrapping modulo n (n <= 16).
    function automatic logic [3:0] rr_next(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int          n
    );
        logic [3:0] g;
        int         idx;
        g = ptr;
        for (int k = 16; k >= 1; k--) begin
            if (k <= n) begin
                idx = int'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[3:0]]) begin
                    g = idx[3:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Picks the first request strictly after ptr, wrapping.
module rr_pick
    import stream_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int SRC_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SRC_W-1:0]      ptr,
    output logic [SRC_W-1:0]      grant,
    output logic                  valid
);

    logic [15:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_INPUTS-1:0] = req;
        grant = SRC_W'(rr_next(req_ext, 4'(ptr), NUM_INPUTS));
        valid = |req;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter and mux for stb/ack word streams.
// Optional packet lock holds the grant until last transfers.
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int NUM_INPUTS       = 4,
    parameter int DATA_WIDTH_BYTES = DEFAULT_DATA_WIDTH_BYTES,
    parameter int LOCK_ON_LAST     = 1,
    parameter int SRC_W            = $clog2(NUM_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPUTS*DATA_WIDTH_BYTES*8-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]                in_stb,
    input  logic [NUM_INPUTS-1:0]                in_last,
    output logic [NUM_INPUTS-1:0]                in_ack,
    output logic [DATA_WIDTH_BYTES*8-1:0]        out_data,
    output logic                                 out_stb,
    output logic                                 out_last,
    output logic [SRC_W-1:0]                     out_src,
    input  logic                                 out_ack
);

    localparam int DW = DATA_WIDTH_BYTES * 8;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] lock_idx;
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] sel;
    logic             pick_v;
    logic             sel_v;
    logic             load;
    logic             xfer;

    rr_pick #(
        .NUM_INPUTS(NUM_INPUTS),
        .SRC_W     (SRC_W)
    ) u_pick (
        .req  (in_stb),
        .ptr  (ptr),
        .grant(pick),
        .valid(pick_v)
    );

    // While locked, the owner alone may transfer, even when idle.
    always_comb begin
        sel   = pick;
        sel_v = pick_v;
        if (state == LOCKED) begin
            sel   = lock_idx;
            sel_v = in_stb[lock_idx];
        end
    end

    assign load   = !out_stb || out_ack;
    assign xfer   = load && sel_v && !rst;
    assign in_ack = xfer ? (NUM_INPUTS'(1) << sel) : '0;

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            unique case (state)
                IDLE: begin
                    if (LOCK_ON_LAST != 0 && !in_last[sel]) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_last[sel]) begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= SRC_W'(NUM_INPUTS - 1);
            lock_idx <= '0;
            out_stb  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            out_src  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                out_stb  <= 1'b1;
                out_data <= in_data[int'(sel)*DW +: DW];
                out_last <= in_last[sel];
                out_src  <= sel;
                ptr      <= sel;
                lock_idx <= sel;
            end else if (out_ack) begin
                out_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter, locked and unlocked builds.
// Both instances share stimulus; the bench follows one at a time.
module tb_stream_rr_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]    in_stb;
    logic [NI-1:0]    in_last;
    logic [NI-1:0]    ack_l;
    logic [NI-1:0]    ack_n;
    logic [DW-1:0]    od_l;
    logic [DW-1:0]    od_n;
    logic             os_l;
    logic             os_n;
    logic             ol_l;
    logic             ol_n;
    logic [1:0]       src_l;
    logic [1:0]       src_n;
    logic             out_ack;

    stream_rr_arbiter #(
        .NUM_INPUTS      (NI),
        .DATA_WIDTH_BYTES(4),
        .LOCK_ON_LAST    (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_stb  (in_stb),
        .in_last (in_last),
        .in_ack  (ack_l),
        .out_data(od_l),
        .out_stb (os_l),
        .out_last(ol_l),
        .out_src (src_l),
        .out_ack (out_ack)
    );

    stream_rr_arbiter #(
        .NUM_INPUTS      (NI),
        .DATA_WIDTH_BYTES(4),
        .LOCK_ON_LAST    (0)
    ) dut_nl (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_stb  (in_stb),
        .in_last (in_last),
        .in_ack  (ack_n),
        .out_data(od_n),
        .out_stb (os_n),
        .out_last(ol_n),
        .out_src (src_n),
        .out_ack (out_ack)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] mem [NI][16];
    int          head [NI];
    int          tail [NI];

    logic        use_nl = 1'b0;
    logic        bp_en  = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    int          cyc    = 0;
    int          n_in   = 0;
    int          n_out  = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    logic [31:0] log_d [$];
    logic [1:0]  log_s [$];
    logic        log_l [$];
    int          log_c [$];
    logic [31:0] exp_d [$];
    logic [1:0]  exp_s [$];
    logic        exp_l [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (head[i] < tail[i]) begin
                in_stb[i]          = 1'b1;
                in_last[i]         = mem[i][head[i]][32];
                in_data[i*DW +: DW] = mem[i][head[i]][31:0];
            end else begin
                in_stb[i]          = 1'b0;
                in_last[i]         = 1'b0;
                in_data[i*DW +: DW] = '0;
            end
        end
        if (bp_en) out_ack = bp_pat[cyc[1:0]];
    endtask

    task automatic push(input int i, input logic [31:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i]++;
        drive();
    endtask

    task automatic tick();
        logic [NI-1:0] a;
        logic          s;
        logic [31:0]   d;
        logic [1:0]    sr;
        logic          l;
        @(negedge clk);
        a  = use_nl ? ack_n : ack_l;
        s  = use_nl ? os_n : os_l;
        d  = use_nl ? od_n : od_l;
        sr = use_nl ? src_n : src_l;
        l  = use_nl ? ol_n : ol_l;
        check("ack_onehot0", 64'($onehot0(a)), 64'd1);
        check("ack_without_stb", 64'(a & ~in_stb), 64'd0);
        if (rst) check("ack_in_reset", 64'(a), 64'd0);
        else if (s && !out_ack) check("ack_when_full", 64'(a), 64'd0);
        if (hold_v) begin
            check("hold_stb", 64'(s), 64'd1);
            check("hold_data", 64'(d), 64'(hold_d));
        end
        hold_v = s && !out_ack && !rst;
        hold_d = d;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (a[i]) begin
                    head[i]++;
                    n_in++;
                end
            end
            if (s && out_ack) begin
                log_d.push_back(d);
                log_s.push_back(sr);
                log_l.push_back(l);
                log_c.push_back(cyc);
                n_out++;
            end
        end
        cyc++;
        drive();
    endtask

    function automatic logic idle();
        logic r;
        r = use_nl ? !os_n : !os_l;
        for (int i = 0; i < NI; i++) begin
            if (head[i] < tail[i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic clear_log();
        log_d.delete(); log_s.delete(); log_l.delete(); log_c.delete();
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        n_in  = 0;
        n_out = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive();
        tick();
        tick();
        rst    = 1'b0;
        hold_v = 1'b0;
        clear_log();
    endtask

    task automatic run_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!idle() && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_drain"}, 64'(idle()), 64'd1);
    endtask

    task automatic exp_add(input logic [31:0] d, input logic [1:0] s,
                           input logic l);
        exp_d.push_back(d);
        exp_s.push_back(s);
        exp_l.push_back(l);
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_count"}, 64'(log_d.size()), 64'(exp_d.size()));
        check({tag, "_in_eq_out"}, 64'(n_out), 64'(n_in));
        n = (log_d.size() < exp_d.size()) ? log_d.size() : exp_d.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_data%0d", tag, k), 64'(log_d[k]), 64'(exp_d[k]));
            check($sformatf("%s_src%0d", tag, k), 64'(log_s[k]), 64'(exp_s[k]));
            check($sformatf("%s_last%0d", tag, k), 64'(log_l[k]), 64'(exp_l[k]));
        end
    endtask

    initial begin
        rst     = 1'b1;
        out_ack = 1'b1;
        for (int i = 0; i < NI; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive();
        do_reset();
        check("rst_out_stb", 64'(os_l), 64'd0);
        check("rst_out_stb_nl", 64'(os_n), 64'd0);

        // single requester, back-to-back
        push(2, 32'h11, 1'b0);
        push(2, 32'h22, 1'b0);
        push(2, 32'h33, 1'b1);
        exp_add(32'h11, 2'd2, 1'b0);
        exp_add(32'h22, 2'd2, 1'b0);
        exp_add(32'h33, 2'd2, 1'b1);
        run_idle("single", 20);
        compare_log("single");
        if (log_c.size() == 3) begin
            check("single_gap1", 64'(log_c[1] - log_c[0]), 64'd1);
            check("single_gap2", 64'(log_c[2] - log_c[0]), 64'd2);
        end

        // reset clears a register that still holds 0x33
        do_reset();
        check("rst_out_data", 64'(od_l), 64'd0);
        check("rst_out_last", 64'(ol_l), 64'd0);
        check("rst_out_src", 64'(src_l), 64'd0);

        // round robin over single-word packets, pointer wraps
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NI; i++) begin
                push(i, 32'hA0 + 32'(i), 1'b1);
                exp_add(32'hA0 + 32'(i), 2'(i), 1'b1);
            end
        end
        run_idle("rr", 40);
        compare_log("rr");

        // packet lock
        do_reset();
        push(0, 32'h1, 1'b0);
        push(0, 32'h2, 1'b0);
        push(0, 32'h3, 1'b1);
        for (int k = 0; k < 4; k++) push(1, 32'h10 + 32'(k), 1'b1);
        exp_add(32'h1, 2'd0, 1'b0);
        exp_add(32'h2, 2'd0, 1'b0);
        exp_add(32'h3, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) exp_add(32'h10 + 32'(k), 2'd1, 1'b1);
        run_idle("lock", 40);
        compare_log("lock");

        // lock holds while the owner stalls mid-packet
        do_reset();
        push(0, 32'h1, 1'b0);
        push(1, 32'h10, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("stall_count", 64'(log_d.size()), 64'd1);
        check("stall_in1_waits", 64'(head[1]), 64'd0);
        push(0, 32'h2, 1'b1);
        exp_add(32'h1, 2'd0, 1'b0);
        exp_add(32'h2, 2'd0, 1'b1);
        exp_add(32'h10, 2'd1, 1'b1);
        run_idle("stall", 30);
        compare_log("stall");

        // same packets without lock interleave
        use_nl = 1'b1;
        do_reset();
        push(0, 32'h1, 1'b0);
        push(0, 32'h2, 1'b0);
        push(0, 32'h3, 1'b1);
        for (int k = 0; k < 4; k++) push(1, 32'h10 + 32'(k), 1'b1);
        exp_add(32'h1, 2'd0, 1'b0);
        exp_add(32'h10, 2'd1, 1'b1);
        exp_add(32'h2, 2'd0, 1'b0);
        exp_add(32'h11, 2'd1, 1'b1);
        exp_add(32'h3, 2'd0, 1'b1);
        exp_add(32'h12, 2'd1, 1'b1);
        exp_add(32'h13, 2'd1, 1'b1);
        run_idle("nolock", 40);
        compare_log("nolock");
        use_nl = 1'b0;

        // backpressure with out_ack 1,0,0,1
        do_reset();
        bp_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(1, 32'h100 + 32'(k), k == 5);
            exp_add(32'h100 + 32'(k), 2'd1, k == 5);
        end
        run_idle("bp", 60);
        compare_log("bp");
        bp_en   = 1'b0;
        out_ack = 1'b1;

        // reset in the middle of a 4-word packet on input 3
        do_reset();
        for (int k = 0; k < 4; k++) push(3, 32'h300 + 32'(k), k == 3);
        for (int k = 0; k < 10 && head[3] < 2; k++) tick();
        check("mid_in_words", 64'(n_in), 64'd2);
        check("mid_out_words", 64'(n_out), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_stb", 64'(os_l), 64'd0);
        check("mid_discard", 64'(n_out), 64'(n_in - 1));
        rst = 1'b0;
        clear_log();
        push(0, 32'h50, 1'b1);
        exp_add(32'h50, 2'd0, 1'b1);
        exp_add(32'h302, 2'd3, 1'b0);
        exp_add(32'h303, 2'd3, 1'b1);
        run_idle("mid", 30);
        compare_log("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
